// File: rtl/fb_scanout.sv
// 8x8 1-bit framebuffer with rasterizer write port, row-serial clear and scan-out.
// Define FB_XOR_WRITE_EN to make accepted writes XOR-plot instead of overwriting.
module fb_scanout (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       wr_valid,
  input  logic [2:0] wr_x,
  input  logic [2:0] wr_y,
  input  logic       wr_pix,
  output logic       wr_ready,
  input  logic       clear_req,
  input  logic       scan_start,
  output logic       scan_valid,
  input  logic       scan_ready,
  output logic [7:0] scan_data,
  output logic [2:0] scan_row,
  output logic       scan_last,
  output logic       busy
);

  localparam int unsigned ROWS = 8;
  localparam int unsigned COLS = 8;
  localparam int unsigned RW   = 3;

  typedef enum logic [1:0] {IDLE, CLEAR, SCAN} state_e;

  state_e            state_q;
  logic [RW-1:0]     scan_row_q;
  logic [RW-1:0]     clr_row_q;
  logic [COLS-1:0]   fb_q [ROWS];
  logic              wr_fire;

  assign wr_ready   = ena && (state_q != CLEAR);
  assign wr_fire    = wr_valid && wr_ready;
  assign scan_valid = (state_q == SCAN);
  assign busy       = (state_q != IDLE);
  assign scan_row   = scan_row_q;
  assign scan_data  = fb_q[scan_row_q];
  assign scan_last  = scan_valid && (scan_row_q == RW'(7));

  // State, counters and storage all freeze while ena is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      scan_row_q <= '0;
      clr_row_q  <= '0;
      for (int i = 0; i < ROWS; i++) fb_q[i] <= '0;
    end else if (ena) begin
      if (wr_fire) begin
`ifdef FB_XOR_WRITE_EN
        fb_q[wr_y][wr_x] <= fb_q[wr_y][wr_x] ^ wr_pix;
`else
        fb_q[wr_y][wr_x] <= wr_pix;
`endif
      end
      case (state_q)
        IDLE: begin
          if (clear_req) begin
            state_q   <= CLEAR;
            clr_row_q <= '0;
          end else if (scan_start) begin
            state_q    <= SCAN;
            scan_row_q <= '0;
          end
        end
        CLEAR: begin
          fb_q[clr_row_q] <= '0;
          clr_row_q       <= clr_row_q + RW'(1);
          if (clr_row_q == RW'(7)) state_q <= IDLE;
        end
        SCAN: begin
          if (scan_ready) begin
            scan_row_q <= scan_row_q + RW'(1);
            if (scan_row_q == RW'(7)) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
